// File: rtl/bitserial_pkg.sv
// Shared types and defaults for the bit-serial multiplier sequencer and PE arrays.
package bitserial_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        OUT
    } state_e;

    // Width that holds 16 full-scale signed products without overflow.
    function automatic int unsigned acc_width(input int unsigned w);
        return 2 * w + 4;
    endfunction

endpackage

// File: rtl/serial_shift_add.sv
// Shift-add datapath: one partial-product step per cycle, LSB first,
// with the MSB step subtracted to give the multiplier its two's-complement weight.
module serial_shift_add
    import bitserial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned ACCW  = acc_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [DEPTH-1:0] bit_idx,
    output logic [ACCW-1:0]  product
);

    logic [ACCW-1:0] partial_q;
    logic [ACCW-1:0] partial_d;
    logic [ACCW-1:0] b_ext;
    logic [ACCW-1:0] shifted;
    logic [ACCW-1:0] term;

    always_comb begin
        b_ext   = {{(ACCW-WIDTH){b[WIDTH-1]}}, b};
        shifted = b_ext << bit_idx;
        term    = '0;
        if (a[bit_idx]) begin
            term = (bit_idx == DEPTH'(WIDTH - 1)) ? (~shifted + 1'b1) : shifted;
        end
        // Includes the current step so the top can fold it in on the final bit.
        product = partial_q + term;
    end

    always_comb begin
        partial_d = partial_q;
        if (clr || start) begin
            partial_d = '0;
        end else if (en) begin
            partial_d = product;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial_q <= '0;
        end else begin
            partial_q <= partial_d;
        end
    end

endmodule

// File: rtl/bitserial_mac_seq.sv
// Sequencer for the bit-serial MAC: accepts signed pairs, runs WIDTH serial steps each,
// accumulates, and emits the dot product when the pair tagged last finishes.
module bitserial_mac_seq
    import bitserial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned ACCW  = acc_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACCW-1:0]  out_data,
    output logic             busy,
    output logic             pe_clr,
    output logic [DEPTH-1:0] bit_idx
);

    localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             last_q, last_d;
    logic [DEPTH-1:0] bit_idx_q, bit_idx_d;
    logic [ACCW-1:0]  acc_q, acc_d;
    logic [ACCW-1:0]  out_data_q, out_data_d;
    logic             start;
    logic             mul_en;
    logic [ACCW-1:0]  product;

    serial_shift_add #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ACCW  (ACCW)
    ) u_shift_add (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .start   (start),
        .en      (mul_en),
        .a       (a_q),
        .b       (b_q),
        .bit_idx (bit_idx_q),
        .product (product)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        last_d     = last_q;
        bit_idx_d  = bit_idx_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        start      = 1'b0;
        mul_en     = 1'b0;

        if (clr) begin
            state_d    = IDLE;
            bit_idx_d  = '0;
            acc_d      = '0;
            out_data_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d       = in_a;
                        b_d       = in_b;
                        last_d    = in_last;
                        bit_idx_d = '0;
                        start     = 1'b1;
                        state_d   = MUL;
                    end
                end
                MUL: begin
                    mul_en = 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        if (last_q) begin
                            out_data_d = acc_q + product;
                            acc_d      = '0;
                            state_d    = OUT;
                        end else begin
                            acc_d   = acc_q + product;
                            state_d = IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            last_q     <= 1'b0;
            bit_idx_q  <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            last_q     <= last_d;
            bit_idx_q  <= bit_idx_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign pe_clr    = (state_q != MUL);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_bitserial_mac_seq.sv
// Scoreboard bench for bitserial_mac_seq: directed pairs with hand-computed products.
module tb_bitserial_mac_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned ACCW  = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACCW-1:0]  out_data;
    logic             busy;
    logic             pe_clr;
    logic [DEPTH-1:0] bit_idx;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    bitserial_mac_seq #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ACCW  (ACCW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .pe_clr    (pe_clr),
        .bit_idx   (bit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sdata();
        return int'($signed(out_data));
    endfunction

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got %0d expected no output", sdata());
            end else begin
                check("out_data", sdata(), exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !pe_clr) begin
            check("in_ready_in_mul", int'(in_ready), 0);
        end
    end

    task automatic send(input int a, input int b, input bit last, input int exp);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_wait: got in_ready=0 expected 1 within 50 cycles");
        end
        if (last) exp_q.push_back(exp);
        in_valid = 1'b1;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (exp_q.size() != 0 || !in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic wait_out_valid();
        int t = 0;
        while (!out_valid && t < 30) begin
            @(posedge clk); #1; t++;
        end
        check("out_valid_seen", int'(out_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int edges;
        int lo;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_pe_clr", int'(pe_clr), 1);
        check("rst_bit_idx", int'(bit_idx), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", sdata(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency and pe_clr window for (3,5).
        send(3, 5, 1'b1, 15);
        edges = 0;
        lo    = 0;
        while (edges < 20) begin
            @(negedge clk);
            if (out_valid) break;
            if (!pe_clr) lo++;
            @(posedge clk);
            edges++;
        end
        check("latency_edges", edges, 8);
        check("pe_clr_low_cycles", lo, 8);
        @(posedge clk); #1;
        drain();

        send(-128, -128, 1'b1, 16384);
        drain();
        send(-1, 127, 1'b1, -127);
        drain();
        send(127, -128, 1'b1, -16256);
        drain();

        // Dot product: 2 + 12 - 30 - 56.
        send(1, 2, 1'b0, 0);
        send(3, 4, 1'b0, 0);
        send(-5, 6, 1'b0, 0);
        send(7, -8, 1'b1, -72);
        drain();

        // Backpressure on the result.
        out_ready = 1'b0;
        send(-7, 9, 1'b1, -63);
        wait_out_valid();
        repeat (5) begin
            check("stall_out_data", sdata(), -63);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_busy", int'(busy), 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_in_ready", int'(in_ready), 1);
        check("post_hs_out_valid", int'(out_valid), 0);
        drain();

        // Abort mid-multiply; accumulator must restart from zero.
        send(2, 3, 1'b0, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("clr_at_bit_idx", int'(bit_idx), 3);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_in_ready", int'(in_ready), 1);
        check("clr_busy", int'(busy), 0);
        check("clr_bit_idx", int'(bit_idx), 0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("clr_no_output", int'(out_valid), 0);
        send(2, 2, 1'b1, 4);
        drain();

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        send(9, 9, 1'b1, 81);
        wait_out_valid();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_data", sdata(), 0);
        check("arst_busy", int'(busy), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(6, 7, 1'b1, 42);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
